// File: rtl/transceiver_pkg.sv
// Shared command constants, frame ROM and FSM state type for the CC1101 bring-up core.
// Frames are addressed by (frame index, byte position); frame 4 is the status poll loop.
package transceiver_pkg;

  localparam logic [7:0] SRES         = 8'h30;
  localparam logic [7:0] SRX          = 8'h34;
  localparam logic [7:0] IOCFG0       = 8'h02;
  localparam logic [7:0] PKTLEN       = 8'h06;
  localparam logic [7:0] MARCSTATE_RD = 8'hF5;
  localparam logic [7:0] IOCFG0_CFG   = 8'h06;
  localparam logic [7:0] PKTLEN_CFG   = 8'h20;
  localparam logic [7:0] STATUS_PAD   = 8'h00;

  localparam logic [2:0] FRAME_STATUS = 3'd4;

  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_SEL,
    ST_WAIT_RDY,
    ST_SHIFT,
    ST_DESEL,
    ST_GAP
  } state_t;

  function automatic logic [1:0] frame_len(input logic [2:0] frame);
    case (frame)
      3'd0, 3'd3: frame_len = 2'd1;
      default:    frame_len = 2'd2;
    endcase
  endfunction

  function automatic logic [7:0] frame_byte(input logic [2:0] frame, input logic pos);
    case ({frame, pos})
      {3'd0, 1'b0}: frame_byte = SRES;
      {3'd1, 1'b0}: frame_byte = IOCFG0;
      {3'd1, 1'b1}: frame_byte = IOCFG0_CFG;
      {3'd2, 1'b0}: frame_byte = PKTLEN;
      {3'd2, 1'b1}: frame_byte = PKTLEN_CFG;
      {3'd3, 1'b0}: frame_byte = SRX;
      {3'd4, 1'b0}: frame_byte = MARCSTATE_RD;
      {3'd4, 1'b1}: frame_byte = STATUS_PAD;
      default:      frame_byte = 8'h00;
    endcase
  endfunction

  function automatic logic frame_last(input logic [2:0] frame, input logic pos);
    frame_last = ({1'b0, pos} == (frame_len(frame) - 2'd1));
  endfunction

endpackage

// File: rtl/transceiver_integration_core_spi_byte_engine.sv
// SPI mode-0 byte engine: SCLK divider plus 8-bit TX/RX shift registers.
// done is combinational on the final falling edge so a chained start keeps SCLK periodic.
module spi_byte_engine
  import transceiver_pkg::*;
#(
  parameter int CLK_DIV = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       miso_s,
  output logic       sclk,
  output logic       mosi,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_byte
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_cnt_reg;
  logic [2:0]    bit_cnt_reg;
  logic          busy_reg;
  logic          sclk_reg;
  logic [7:0]    tx_reg;
  logic [7:0]    rx_reg;
  logic          tick;

  assign tick = busy_reg && (div_cnt_reg == DW'(CLK_DIV - 1));
  assign done = tick && sclk_reg && (bit_cnt_reg == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      busy_reg    <= 1'b0;
      sclk_reg    <= 1'b0;
      tx_reg      <= '0;
      rx_reg      <= '0;
    end else begin
      if (start) begin
        busy_reg    <= 1'b1;
        div_cnt_reg <= '0;
        bit_cnt_reg <= '0;
        sclk_reg    <= 1'b0;
      end else if (busy_reg) begin
        if (tick) begin
          div_cnt_reg <= '0;
          sclk_reg    <= ~sclk_reg;
          if (sclk_reg) begin
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) busy_reg <= 1'b0;
          end
        end else begin
          div_cnt_reg <= div_cnt_reg + DW'(1);
        end
      end
      // Zeros shift in behind the data, so MOSI idles low once a byte completes.
      if (load) tx_reg <= tx_byte;
      else if (tick && sclk_reg) tx_reg <= {tx_reg[6:0], 1'b0};
      if (tick && !sclk_reg) rx_reg <= {rx_reg[6:0], miso_s};
    end
  end

  assign sclk    = sclk_reg;
  assign mosi    = tx_reg[7];
  assign busy    = busy_reg;
  assign rx_byte = rx_reg;

endmodule

// File: rtl/transceiver_integration_core.sv
// Brings up a CC1101-style transceiver over SPI: startup wait, init command frames,
// then endless MARCSTATE polling with the last status byte kept in rx_last.
module transceiver_integration_core
  import transceiver_pkg::*;
#(
  parameter int CLK_DIV        = 24,
  parameter int STARTUP_CYCLES = 2000,
  parameter int GAP_CYCLES     = 48
) (
  input  logic CLK_48MHZ,
  input  logic BUF2_PBRST_T9,
  input  logic MISO,
  output logic SS,
  output logic MOSI,
  output logic SCLK
);

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [2:0]  frame_reg, frame_next;
  logic        pos_reg, pos_next;
  logic [7:0]  rx_last, rx_last_next;
  logic        ss_reg;
  logic        miso_meta, miso_s;
  logic        eng_load, eng_start, eng_busy, eng_done;
  logic [7:0]  eng_tx, eng_rx;
  logic        byte_last;

  assign byte_last = frame_last(frame_reg, pos_reg);

  always_ff @(posedge CLK_48MHZ or negedge BUF2_PBRST_T9) begin
    if (!BUF2_PBRST_T9) begin
      miso_meta <= 1'b0;
      miso_s    <= 1'b0;
    end else begin
      miso_meta <= MISO;
      miso_s    <= miso_meta;
    end
  end

  always_ff @(posedge CLK_48MHZ or negedge BUF2_PBRST_T9) begin
    if (!BUF2_PBRST_T9) begin
      state_reg <= ST_STARTUP;
      cnt_reg   <= '0;
      frame_reg <= '0;
      pos_reg   <= 1'b0;
      rx_last   <= '0;
      ss_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      frame_reg <= frame_next;
      pos_reg   <= pos_next;
      rx_last   <= rx_last_next;
      // SS is registered from the next state so the pin never sees decode glitches.
      ss_reg    <= (state_next == ST_STARTUP) || (state_next == ST_GAP);
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = '0;
    frame_next   = frame_reg;
    pos_next     = pos_reg;
    rx_last_next = rx_last;
    case (state_reg)
      ST_STARTUP: begin
        cnt_next = cnt_reg + 16'd1;
        if (cnt_reg == 16'(STARTUP_CYCLES - 1)) begin
          state_next = ST_SEL;
          cnt_next   = '0;
        end
      end
      ST_SEL: state_next = ST_WAIT_RDY;
      ST_WAIT_RDY: begin
        if (!miso_s && !eng_busy) state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (eng_done) begin
          if (byte_last) begin
            state_next = ST_DESEL;
            if (frame_reg == FRAME_STATUS) rx_last_next = eng_rx;
          end else begin
            pos_next = pos_reg + 1'b1;
          end
        end
      end
      ST_DESEL: begin
        cnt_next = cnt_reg + 16'd1;
        if (cnt_reg == 16'(CLK_DIV - 1)) begin
          state_next = ST_GAP;
          cnt_next   = '0;
        end
      end
      ST_GAP: begin
        cnt_next = cnt_reg + 16'd1;
        if (cnt_reg == 16'(GAP_CYCLES - 1)) begin
          state_next = ST_SEL;
          cnt_next   = '0;
          pos_next   = 1'b0;
          if (frame_reg != FRAME_STATUS) frame_next = frame_reg + 3'd1;
        end
      end
      default: state_next = ST_STARTUP;
    endcase
  end

  // The engine's first CLK_DIV count after start doubles as the chip-ready setup time.
  always_comb begin
    eng_load  = 1'b0;
    eng_start = 1'b0;
    eng_tx    = frame_byte(frame_reg, pos_reg);
    case (state_reg)
      ST_SEL:      eng_load = 1'b1;
      ST_WAIT_RDY: eng_start = !miso_s && !eng_busy;
      ST_SHIFT: begin
        if (eng_done && !byte_last) begin
          eng_load  = 1'b1;
          eng_start = 1'b1;
          eng_tx    = frame_byte(frame_reg, pos_reg + 1'b1);
        end
      end
      default: ;
    endcase
  end

  spi_byte_engine #(
    .CLK_DIV (CLK_DIV)
  ) u_engine (
    .clk     (CLK_48MHZ),
    .rst_n   (BUF2_PBRST_T9),
    .load    (eng_load),
    .start   (eng_start),
    .tx_byte (eng_tx),
    .miso_s  (miso_s),
    .sclk    (SCLK),
    .mosi    (MOSI),
    .busy    (eng_busy),
    .done    (eng_done),
    .rx_byte (eng_rx)
  );

  assign SS = ss_reg;

endmodule

// File: tb/tb_transceiver_integration_core.sv
// Bench for transceiver_integration_core: a transceiver model drives MISO per frame and
// pushes expectations; an independent SPI monitor reassembles frames and checks them.
module tb_transceiver_integration_core;

  localparam int CLK_DIV        = 24;
  localparam int STARTUP_CYCLES = 2000;
  localparam int GAP_CYCLES     = 48;

  logic clk;
  logic rst_n;
  logic MISO;
  logic SS;
  logic MOSI;
  logic SCLK;

  int checks = 0;
  int errors = 0;

  int          exp_len_q[$];
  logic [15:0] exp_dat_q[$];
  logic [7:0]  exp_rx_q[$];
  logic [7:0]  exp_rx;

  int          tbl_len [4] = '{1, 2, 2, 1};
  logic [15:0] tbl_dat [4] = '{16'h0030, 16'h0206, 16'h0620, 16'h0034};

  transceiver_integration_core #(
    .CLK_DIV        (CLK_DIV),
    .STARTUP_CYCLES (STARTUP_CYCLES),
    .GAP_CYCLES     (GAP_CYCLES)
  ) dut (
    .CLK_48MHZ     (clk),
    .BUF2_PBRST_T9 (rst_n),
    .MISO          (MISO),
    .SS            (SS),
    .MOSI          (MOSI),
    .SCLK          (SCLK)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic chk_range(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic abort(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout, expected DUT event", name);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  // which: 0 = SS, 1 = SCLK; samples on falling clk edges
  task automatic wait_level(input string name, input int which, input logic lvl,
                            input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((which == 0) ? SS : SCLK) !== lvl && n < limit);
    if (((which == 0) ? SS : SCLK) !== lvl) abort(name);
  endtask

  // Transceiver model for one frame: optional chip-ready stall, then status bits on MISO.
  task automatic serve_frame(input int fno, output int waited);
    int len, nb, stall, n, highs;
    logic [15:0] data, rxb;
    if (fno < 4) begin
      len  = tbl_len[fno];
      data = tbl_dat[fno];
    end else begin
      len  = 2;
      data = 16'hF500;
    end
    nb  = 8 * len;
    rxb = 16'($urandom);
    if (fno == 4) rxb[7:0] = 8'hFF;
    else if (fno == 5) rxb[7:0] = 8'h0D;
    rxb[nb-1] = 1'b0;
    if (fno >= 4) exp_rx = rxb[7:0];
    exp_len_q.push_back(len);
    exp_dat_q.push_back(data);
    exp_rx_q.push_back(exp_rx);
    stall = (fno == 2 || $urandom_range(0, 3) == 0) ? int'($urandom_range(150, 250)) : 0;
    MISO = (stall > 0);
    wait_level("ss_fall", 0, 1'b0, 5000, waited);
    if (stall > 0) begin
      highs = 0;
      repeat (stall) begin
        @(negedge clk);
        if (SCLK) highs++;
      end
      chk("stall_sclk_low", highs, 0);
      MISO = 1'b0;
      wait_level("ready_sclk", 1, 1'b1, 200, n);
      chk_range("ready_to_sclk", n, 26, 28);
    end
    for (int i = 1; i < nb; i++) begin
      wait_level("sclk_rise", 1, 1'b1, 200, n);
      wait_level("sclk_fall", 1, 1'b0, 200, n);
      MISO = rxb[nb-1-i];
    end
    wait_level("sclk_rise", 1, 1'b1, 200, n);
    wait_level("sclk_fall", 1, 1'b0, 200, n);
    wait_level("ss_rise", 0, 1'b1, 100, n);
  endtask

  int          mon_cyc = 0, mon_nbits = 0, mon_last_rise = 0, mon_last_fall = 0;
  int          mon_ss_rise = 0, mon_frames = 0;
  bit          mon_in_frame = 0, mon_have_gap = 0;
  logic        mon_ss_q = 1'b1, mon_sclk_q = 1'b0;
  logic [31:0] mon_cap = '0;

  initial begin
    int          elen;
    logic [15:0] edat;
    logic [7:0]  erx;
    forever begin
      @(negedge clk);
      mon_cyc++;
      if (!rst_n) begin
        mon_in_frame = 0;
        mon_have_gap = 0;
        mon_ss_q     = 1'b1;
        mon_sclk_q   = 1'b0;
      end else begin
        if (mon_ss_q && !SS) begin
          mon_in_frame = 1;
          mon_nbits    = 0;
          mon_cap      = '0;
          if (mon_have_gap) chk("ss_gap", mon_cyc - mon_ss_rise, GAP_CYCLES);
        end
        if (mon_in_frame && !mon_sclk_q && SCLK) begin
          if (mon_nbits > 0) chk("sclk_period", mon_cyc - mon_last_rise, 2 * CLK_DIV);
          mon_last_rise = mon_cyc;
          mon_cap       = {mon_cap[30:0], MOSI};
          mon_nbits++;
        end
        if (mon_in_frame && mon_sclk_q && !SCLK) mon_last_fall = mon_cyc;
        if (mon_in_frame && !mon_ss_q && SS) begin
          chk("ss_rise_delay", mon_cyc - mon_last_fall, CLK_DIV);
          if (exp_len_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got frame mosi=%0h, expected none", mon_cap);
          end else begin
            elen = exp_len_q.pop_front();
            edat = exp_dat_q.pop_front();
            erx  = exp_rx_q.pop_front();
            chk("frame_bits", mon_nbits, 8 * elen);
            chk("frame_mosi", int'(mon_cap), int'(edat));
            chk("rx_last", int'(dut.rx_last), int'(erx));
          end
          $display("frame %0d: mosi=%0h bits=%0d rx_last=%02h", mon_frames, mon_cap,
                   mon_nbits, dut.rx_last);
          mon_frames++;
          mon_in_frame = 0;
          mon_have_gap = 1;
          mon_ss_rise  = mon_cyc;
        end
        mon_ss_q   = SS;
        mon_sclk_q = SCLK;
      end
    end
  end

  initial begin
    int w, n;
    rst_n  = 1'b0;
    MISO   = 1'b0;
    exp_rx = 8'h00;
    repeat (10) @(negedge clk);
    chk("reset_ss", int'(SS), 1);
    chk("reset_sclk", int'(SCLK), 0);
    chk("reset_mosi", int'(MOSI), 0);
    chk("reset_rx_last", int'(dut.rx_last), 0);
    rst_n = 1'b1;
    for (int f = 0; f < 9; f++) begin
      serve_frame(f, w);
      if (f == 0) chk_range("startup_delay", w, STARTUP_CYCLES, STARTUP_CYCLES + 1);
    end

    MISO = 1'b0;
    wait_level("mid_ss_fall", 0, 1'b0, 5000, n);
    wait_level("mid_sclk_high", 1, 1'b1, 200, n);
    #3 rst_n = 1'b0;
    #1;
    chk("midreset_ss", int'(SS), 1);
    chk("midreset_sclk", int'(SCLK), 0);
    chk("midreset_mosi", int'(MOSI), 0);
    repeat (5) @(negedge clk);
    chk("midreset_rx_last", int'(dut.rx_last), 0);
    exp_rx = 8'h00;
    rst_n  = 1'b1;
    for (int f = 0; f < 6; f++) begin
      serve_frame(f, w);
      if (f == 0) chk_range("restart_delay", w, STARTUP_CYCLES, STARTUP_CYCLES + 1);
    end
    repeat (2) @(negedge clk);
    chk("frames_drained", exp_len_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
